// File: rtl/mmio_pkg.sv
// Shared constants and types for the MEM-stage MMIO responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: register byte offsets within the 64-byte I/O window, LED/switch
// widths, the 3-bit register index type and a helper mapping offset -> index.
package mmio_pkg;

  localparam int LED_W = 27;
  localparam int SW_W  = 18;

  // Register index = address[5:3]; every register is one 64-bit word.
  typedef logic [2:0] reg_idx_t;

  localparam logic [5:0] OFF_LED     = 6'h00;
  localparam logic [5:0] OFF_SWITCH  = 6'h08;
  localparam logic [5:0] OFF_SW_EDGE = 6'h10;
  localparam logic [5:0] OFF_CYCLE   = 6'h18;
  localparam logic [5:0] OFF_CMP     = 6'h20;
  localparam logic [5:0] OFF_STATUS  = 6'h28;

  function automatic reg_idx_t reg_idx(input logic [5:0] off);
    return off[5:3];
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Synchronises raw board switches and accepts a new level once it is stable.
// Latency: 2 + DEBOUNCE_CYCLES clocks with MMIO_DEBOUNCE_EN, 2 clocks without.
// Backpressure: none; free-running sampling path.
// Ports: clock, reset (sync, active-high), i_sw_raw (async switches),
//   o_stable (accepted level), o_rise (bits whose accepted level goes 0->1 at
//   the coming edge, so a capture register sets in step with o_stable).
// Build option: MMIO_DEBOUNCE_EN adds per-bit debounce counters.
module switch_debouncer
  import mmio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [SW_W-1:0] i_sw_raw,
  output logic [SW_W-1:0] o_stable,
  output logic [SW_W-1:0] o_rise
);

  logic [SW_W-1:0] r_sync1;
  logic [SW_W-1:0] r_sync2;
  logic [SW_W-1:0] w_stable_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_sw_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef MMIO_DEBOUNCE_EN
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0]  r_stable;
  logic [CNT_W-1:0] r_cnt     [SW_W];
  logic [CNT_W-1:0] w_cnt_nxt [SW_W];

  // A bit flips only after disagreeing with the accepted level on
  // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
  always_comb begin
    w_stable_nxt = r_stable;
    for (int b = 0; b < SW_W; b++) begin
      w_cnt_nxt[b] = '0;
      if (r_sync2[b] != r_stable[b]) begin
        if (r_cnt[b] == CNT_LAST) begin
          w_stable_nxt[b] = r_sync2[b];
        end else begin
          w_cnt_nxt[b] = r_cnt[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stable <= '0;
      for (int b = 0; b < SW_W; b++) r_cnt[b] <= '0;
    end else begin
      r_stable <= w_stable_nxt;
      for (int b = 0; b < SW_W; b++) r_cnt[b] <= w_cnt_nxt[b];
    end
  end

  assign o_stable = r_stable;
`else
  // Without debouncing the synchroniser output is the accepted level.
  localparam int debounce_cycles_unused = DEBOUNCE_CYCLES;
  assign w_stable_nxt = r_sync1;
  assign o_stable     = r_sync2;
`endif

  assign o_rise = w_stable_nxt & ~o_stable;

endmodule

// File: rtl/mmio_io_responder.sv
// MEM-stage MMIO responder: LEDs, debounced switches, edge capture, cycle timer.
// Latency: reads are combinational (zero-latency); writes commit at the next edge.
// Backpressure: none; every access is served in the cycle it is presented.
// Ports: clock, reset (sync, active-high); address/write_data/MemRead/MemWrite
//   from EX/MEM; read_data, hit back to the MEM mux; switches (raw async in),
//   leds (register drive), timer_irq (sticky compare flag).
// Build option: MMIO_DEBOUNCE_EN enables switch debounce counters.
module mmio_io_responder
  import mmio_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR       = 64'h0000_0000_0000_1000,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [63:0]      address,
  input  logic [63:0]      write_data,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic [63:0]      read_data,
  output logic             hit,
  input  logic [SW_W-1:0]  switches,
  output logic [LED_W-1:0] leds,
  output logic             timer_irq
);

  logic [LED_W-1:0] r_leds;
  logic [SW_W-1:0]  r_sw_edge;
  logic [63:0]      r_cycle;
  logic [63:0]      r_cmp;
  logic             r_flag;

  logic             w_in_win;
  reg_idx_t         w_sel;
  logic             w_wr;
  logic [63:0]      w_rdata;
  logic [63:0]      w_cycle_nxt;
  logic [SW_W-1:0]  w_sw_stable;
  logic [SW_W-1:0]  w_sw_rise;
  logic [SW_W-1:0]  w_edge_clr;
  logic [2:0]       w_addr_lsb_unused;

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw (
    .clock    (clock),
    .reset    (reset),
    .i_sw_raw (switches),
    .o_stable (w_sw_stable),
    .o_rise   (w_sw_rise)
  );

  // Byte lane within the word is irrelevant: any offset hits the whole word.
  assign w_addr_lsb_unused = address[2:0];
  assign w_in_win = (address[63:6] == BASE_ADDR[63:6]);
  assign w_sel    = address[5:3];
  assign hit      = w_in_win & (MemRead | MemWrite);
  assign w_wr     = w_in_win & MemWrite;

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      reg_idx(OFF_LED):     w_rdata = {{(64-LED_W){1'b0}}, r_leds};
      reg_idx(OFF_SWITCH):  w_rdata = {{(64-SW_W){1'b0}}, w_sw_stable};
      reg_idx(OFF_SW_EDGE): w_rdata = {{(64-SW_W){1'b0}}, r_sw_edge};
      reg_idx(OFF_CYCLE):   w_rdata = r_cycle;
      reg_idx(OFF_CMP):     w_rdata = r_cmp;
      reg_idx(OFF_STATUS):  w_rdata = {63'd0, r_flag};
      default:              w_rdata = '0;
    endcase
  end

  // Current register state, so a combined read+write returns the old value.
  assign read_data = (w_in_win & MemRead) ? w_rdata : '0;

  assign w_edge_clr  = (w_wr && w_sel == reg_idx(OFF_SW_EDGE)) ? write_data[SW_W-1:0] : '0;
  assign w_cycle_nxt = (w_wr && w_sel == reg_idx(OFF_CYCLE)) ? write_data : r_cycle + 64'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_leds    <= '0;
      r_sw_edge <= '0;
      r_cycle   <= '0;
      r_cmp     <= '1;
      r_flag    <= 1'b0;
    end else begin
      if (w_wr && w_sel == reg_idx(OFF_LED)) r_leds <= write_data[LED_W-1:0];
      if (w_wr && w_sel == reg_idx(OFF_CMP)) r_cmp  <= write_data;
      // New edges dominate a same-cycle write-1-to-clear.
      r_sw_edge <= (r_sw_edge & ~w_edge_clr) | w_sw_rise;
      r_cycle   <= w_cycle_nxt;
      // Match looks at the value CYCLE is about to take; set dominates clear.
      if (w_cycle_nxt == r_cmp) begin
        r_flag <= 1'b1;
      end else if (w_wr && w_sel == reg_idx(OFF_STATUS) && write_data[0]) begin
        r_flag <= 1'b0;
      end
    end
  end

  assign leds      = r_leds;
  assign timer_irq = r_flag;

endmodule

// File: tb/tb_mmio_io_responder.sv
`timescale 1ns/1ps
module tb_mmio_io_responder;
  import mmio_pkg::*;

  localparam logic [63:0] BASE = 64'h0000_0000_0000_1000;
  localparam int          DC   = 4;
`ifdef MMIO_DEBOUNCE_EN
  localparam int LAT = 2 + DC;
`else
  localparam int LAT = 2;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic [63:0]      address, write_data, read_data;
  logic             MemRead, MemWrite, hit, timer_irq;
  logic [SW_W-1:0]  switches;
  logic [LED_W-1:0] leds;

  always #5 clock = ~clock;

  mmio_io_responder #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(DC)) dut (
    .clock(clock), .reset(reset), .address(address), .write_data(write_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .read_data(read_data), .hit(hit),
    .switches(switches), .leds(leds), .timer_irq(timer_irq)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: dut=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [LED_W-1:0] m_leds;
  logic [SW_W-1:0]  m_stable, m_s1, m_s2, m_edge;
  int               m_run [SW_W];
  logic [63:0]      m_cycle, m_cmp;
  logic             m_flag;

  function automatic bit m_inwin(input logic [63:0] a);
    return (a >> 6) == (BASE >> 6);
  endfunction

  function automatic logic [63:0] m_reg(input logic [2:0] idx);
    case (idx)
      3'd0: return 64'(m_leds);
      3'd1: return 64'(m_stable);
      3'd2: return 64'(m_edge);
      3'd3: return m_cycle;
      3'd4: return m_cmp;
      3'd5: return 64'(m_flag);
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clock) begin : model
    logic [SW_W-1:0] nst;
    logic [63:0]     ncyc;
    logic [2:0]      idx;
    bit              w;
    if (reset) begin
      m_leds = '0; m_stable = '0; m_s1 = '0; m_s2 = '0; m_edge = '0;
      m_cycle = '0; m_cmp = '1; m_flag = 1'b0;
      for (int b = 0; b < SW_W; b++) m_run[b] = 0;
    end else begin
`ifdef MMIO_DEBOUNCE_EN
      // Accept a level after DC consecutive disagreeing synchronised samples.
      nst = m_stable;
      for (int b = 0; b < SW_W; b++) begin
        if (m_s2[b] != m_stable[b]) begin
          m_run[b]++;
          if (m_run[b] == DC) begin
            nst[b] = ~nst[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
`else
      nst = m_s1;
`endif
      w   = MemWrite && m_inwin(address);
      idx = address[5:3];
      ncyc = (w && idx == 3'd3) ? write_data : m_cycle + 64'd1;
      if (w && idx == 3'd0) m_leds = write_data[LED_W-1:0];
      if (w && idx == 3'd2) m_edge = m_edge & ~write_data[SW_W-1:0];
      m_edge = m_edge | (nst & ~m_stable);
      if (ncyc == m_cmp) m_flag = 1'b1;
      else if (w && idx == 3'd5 && write_data[0]) m_flag = 1'b0;
      if (w && idx == 3'd4) m_cmp = write_data;
      m_cycle  = ncyc;
      m_stable = nst;
      m_s2 = m_s1;
      m_s1 = switches;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("hit", 64'(hit), 64'(m_inwin(address) && (MemRead || MemWrite)));
      chk("read_data", read_data, (m_inwin(address) && MemRead) ? m_reg(address[5:3]) : 64'd0);
      chk("leds", 64'(leds), 64'(m_leds));
      chk("timer_irq", 64'(timer_irq), 64'(m_flag));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [63:0] a, input logic [63:0] d, input bit rd, input bit wr);
    address = a; write_data = d; MemRead = rd; MemWrite = wr;
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; switches = '0;
    address = '0; write_data = '0; MemRead = 1'b0; MemWrite = 1'b0;
    @(posedge clock); #1;
    chk_en = 1'b1;
    tick(2);
    reset = 1'b0;

    // Reset state and decode
    drive(BASE + 64'h18, 0, 1, 0);
    chk("rst_cycle", read_data, 64'd0);
    chk("rst_leds", 64'(leds), 64'd0);
    chk("rst_irq", 64'(timer_irq), 64'd0);
    tick(1);
    drive(BASE + 64'h20, 0, 1, 0);
    chk("rst_cmp", read_data, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(BASE + 64'h08, 0, 1, 0);
    chk("sw_hit", 64'(hit), 64'd1);
    chk("sw_zero", read_data, 64'd0);
    tick(1);
    drive(64'h0FF8, 0, 1, 0);
    chk("oow_hit", 64'(hit), 64'd0);
    chk("oow_data", read_data, 64'd0);
    drive(BASE + 64'h30, 64'h55, 1, 1);
    chk("rsvd_hit", 64'(hit), 64'd1);
    chk("rsvd_data", read_data, 64'd0);
    tick(1);

    // LED store/readback, byte offset, read+write same cycle
    drive(BASE, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
    tick(1);
    chk("led_all", 64'(leds), 64'h7FF_FFFF);
    drive(BASE, 0, 1, 0);
    chk("led_rb", read_data, 64'h0000_0000_07FF_FFFF);
    drive(BASE + 64'h3, 64'h15, 0, 1);
    tick(1);
    chk("led_off3", 64'(leds), 64'h15);
    drive(BASE, 64'h2A, 1, 1);
    chk("rw_old", read_data, 64'h15);
    tick(1);
    chk("rw_new", 64'(leds), 64'h2A);

    // Switch acceptance latency and glitch rejection
    drive(0, 0, 0, 0);
    switches = 18'h00001;
    tick(LAT - 1);
    drive(BASE + 64'h08, 0, 1, 0);
    chk("sw_pre", read_data, 64'd0);
    tick(1);
    chk("sw_acc", read_data, 64'd1);
    drive(BASE + 64'h10, 0, 1, 0);
    chk("edge_b0", 64'(read_data[0]), 64'd1);
    switches = 18'h00003;
    tick(3);
    switches = 18'h00001;
    tick(LAT + 6);
    drive(BASE + 64'h08, 0, 1, 0);
    chk("glitch_sw", read_data, 64'd1);
`ifdef MMIO_DEBOUNCE_EN
    drive(BASE + 64'h10, 0, 1, 0);
    chk("glitch_edge", 64'(read_data[1]), 64'd0);
`endif

    // Edge set dominates same-cycle W1C
    switches = 18'h0;
    tick(LAT + 2);
    switches = 18'h1;
    tick(LAT - 1);
    drive(BASE + 64'h10, 64'h1, 0, 1);
    tick(1);
    drive(BASE + 64'h10, 0, 1, 0);
    chk("edge_dom", 64'(read_data[0]), 64'd1);
    drive(BASE + 64'h10, 64'h1, 0, 1);
    tick(1);
    drive(BASE + 64'h10, 0, 1, 0);
    chk("edge_clr", 64'(read_data[0]), 64'd0);

    // CYCLE wrap (CMP still all-ones, so the flag fires at ...FFFF)
    drive(BASE + 64'h18, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1);
    tick(1);
    drive(BASE + 64'h18, 0, 1, 0);
    chk("cyc_fe", read_data, 64'hFFFF_FFFF_FFFF_FFFE);
    tick(1);
    chk("cyc_ff", read_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("irq_ff", 64'(timer_irq), 64'd1);
    tick(1);
    chk("cyc_wrap", read_data, 64'd0);
    drive(BASE + 64'h28, 0, 1, 0);
    chk("status_rd", read_data, 64'd1);
    drive(BASE + 64'h28, 64'h1, 0, 1);
    tick(1);
    chk("irq_clr0", 64'(timer_irq), 64'd0);

    // Compare match
    drive(BASE + 64'h20, 64'd20, 0, 1);
    tick(1);
    drive(BASE + 64'h18, 64'd10, 0, 1);
    tick(1);
    drive(0, 0, 0, 0);
    tick(9);
    drive(BASE + 64'h18, 0, 1, 0);
    chk("cyc_19", read_data, 64'd19);
    chk("irq_19", 64'(timer_irq), 64'd0);
    tick(1);
    chk("cyc_20", read_data, 64'd20);
    chk("irq_20", 64'(timer_irq), 64'd1);
    tick(3);
    chk("irq_sticky", 64'(timer_irq), 64'd1);
    drive(BASE + 64'h28, 64'h1, 0, 1);
    tick(1);
    chk("irq_clr", 64'(timer_irq), 64'd0);

    // Reset mid-operation
    drive(BASE, 64'h3, 0, 1);
    tick(1);
    reset = 1'b1;
    drive(0, 0, 0, 0);
    tick(1);
    reset = 1'b0;
    chk("mid_rst_leds", 64'(leds), 64'd0);
    drive(BASE + 64'h20, 0, 1, 0);
    chk("mid_rst_cmp", read_data, 64'hFFFF_FFFF_FFFF_FFFF);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] a, d;
      int k;
      if ($urandom_range(0, 9) < 8) a = BASE | 64'($urandom_range(0, 63));
      else a = {$urandom, $urandom};
      d = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) d = m_cycle + 64'($urandom_range(1, 30));
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, SW_W - 1);
        switches[k] = ~switches[k];
      end
      reset = ($urandom_range(0, 199) == 0);
      drive(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick(1);
    end
    reset = 1'b0;
    drive(0, 0, 0, 0);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
